// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_master
// Description : Single-outstanding bus master bridging a CPU request/done
//               port onto the io_bus_* slave interface. Performs an address
//               window check, holds sel until ack, captures read data and
//               aborts a bus cycle that is never acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_master #(
    parameter logic [31:0]     IO_BASE = 32'hFFFF_0000,
    parameter logic [31:0]     IO_MASK = 32'hFFFF_0000,
    parameter int              TO_W    = 8,
    parameter logic [TO_W-1:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic        cpu_busy,
    output logic [31:0] io_bus_addr,
    output logic [31:0] io_bus_dat2,
    input  logic [31:0] io_bus_dat4,
    output logic        io_bus_sel,
    output logic        io_bus_we,
    input  logic        io_bus_ack
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_bus  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [TO_W-1:0] c_cnt_one = {{(TO_W-1){1'b0}}, 1'b1};
    // Last counter value at which a missing ack aborts the cycle.
    localparam logic [TO_W-1:0] c_to_last = TIMEOUT - c_cnt_one;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [TO_W-1:0] r_cnt;
    logic [TO_W-1:0] w_cnt_nxt;

    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_done,  w_done_nxt;
    logic        r_err,   w_err_nxt;
    logic        r_busy,  w_busy_nxt;
    logic [31:0] r_addr,  w_addr_nxt;
    logic [31:0] r_dat2,  w_dat2_nxt;
    logic        r_sel,   w_sel_nxt;
    logic        r_we,    w_we_nxt;

    logic w_in_window;
    logic w_ack;
    logic w_timeout;

    assign w_in_window = ((cpu_addr & IO_MASK) == IO_BASE);
    // Ack is only meaningful while a bus cycle is in flight.
    assign w_ack       = (r_state == c_st_bus) && io_bus_ack;
    // Ack on the final cycle takes priority over the abort.
    assign w_timeout   = (r_state == c_st_bus) && !io_bus_ack && (r_cnt == c_to_last);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: IDLE accepts, BUS waits for ack/abort, DONE lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (cpu_req) begin
                    w_next_state = w_in_window ? c_st_bus : c_st_done;
                end
            end
            c_st_bus: begin
                if (w_ack || w_timeout) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    // Next values of the registered outputs; bus fields hold outside IDLE acceptance.
    always_comb begin
        w_rdata_nxt = r_rdata;
        w_err_nxt   = r_err;
        w_addr_nxt  = r_addr;
        w_dat2_nxt  = r_dat2;
        w_we_nxt    = r_we;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = (w_next_state == c_st_bus);
        w_done_nxt  = (w_next_state == c_st_done);
        w_busy_nxt  = (w_next_state != c_st_idle);
        case (r_state)
            c_st_idle: begin
                if (cpu_req) begin
                    w_addr_nxt = cpu_addr;
                    w_dat2_nxt = cpu_wdata;
                    w_we_nxt   = cpu_we;
                    w_cnt_nxt  = '0;
                    w_err_nxt  = !w_in_window;
                    if (!w_in_window) begin
                        w_rdata_nxt = '0;
                    end
                end
            end
            c_st_bus: begin
                w_cnt_nxt = r_cnt + c_cnt_one;
                if (w_ack) begin
                    w_err_nxt   = 1'b0;
                    w_rdata_nxt = r_we ? 32'h0 : io_bus_dat4;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                end
            end
            default: begin
                w_cnt_nxt = r_cnt;
            end
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_dat2  <= '0;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_rdata <= w_rdata_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            r_addr  <= w_addr_nxt;
            r_dat2  <= w_dat2_nxt;
            r_sel   <= w_sel_nxt;
            r_we    <= w_we_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign cpu_rdata   = r_rdata;
    assign cpu_done    = r_done;
    assign cpu_err     = r_err;
    assign cpu_busy    = r_busy;
    assign io_bus_addr = r_addr;
    assign io_bus_dat2 = r_dat2;
    assign io_bus_sel  = r_sel;
    assign io_bus_we   = r_we;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_bus_master
// Description : Self-checking bench for io_bus_master. A behavioural slave
//               acks after a programmable delay; expected completions are
//               queued at request time and compared when cpu_done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bus_master;

    localparam int c_timeout = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        cpu_busy;
    logic [31:0] io_bus_addr;
    logic [31:0] io_bus_dat2;
    logic [31:0] io_bus_dat4 = '0;
    logic        io_bus_sel;
    logic        io_bus_we;
    logic        io_bus_ack = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rdata;
        int          sel_cycles;
    } exp_t;

    exp_t exp_q[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int sel_run  = 0;

    int          ack_delay   = 0;
    logic        stray_ack   = 1'b0;
    logic [31:0] slave_rdata = '0;
    int          slv_cnt     = 0;

    io_bus_master #(
        .IO_BASE (32'hFFFF_0000),
        .IO_MASK (32'hFFFF_0000),
        .TO_W    (8),
        .TIMEOUT (8'd4)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_done    (cpu_done),
        .cpu_err     (cpu_err),
        .cpu_busy    (cpu_busy),
        .io_bus_addr (io_bus_addr),
        .io_bus_dat2 (io_bus_dat2),
        .io_bus_dat4 (io_bus_dat4),
        .io_bus_sel  (io_bus_sel),
        .io_bus_we   (io_bus_we),
        .io_bus_ack  (io_bus_ack)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Main stimulus steps land 2 units after the edge, after the monitor has sampled.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Slave model: acks ack_delay cycles after sel rises (negative = never); stray ack when idle.
    always begin
        @(posedge clk);
        #3;
        if (io_bus_sel) begin
            if (ack_delay >= 0 && slv_cnt == ack_delay) begin
                io_bus_ack  = 1'b1;
                io_bus_dat4 = slave_rdata;
            end else begin
                io_bus_ack  = 1'b0;
                io_bus_dat4 = 32'h0BAD_0000;
            end
            slv_cnt++;
        end else begin
            slv_cnt     = 0;
            io_bus_ack  = stray_ack;
            io_bus_dat4 = 32'h0BAD_1111;
        end
    end

    // Monitor: measures sel length and scores every completion pulse.
    always begin : mon
        exp_t e;
        @(posedge clk);
        #1;
        if (cpu_done) begin
            done_cnt++;
            check_val("sel_in_done", {31'b0, io_bus_sel}, 32'd0);
            check_val("busy_in_done", {31'b0, cpu_busy}, 32'd1);
            if (exp_q.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("done_err", {31'b0, cpu_err}, {31'b0, e.err});
                if (e.chk_rdata) begin
                    check_val("done_rdata", cpu_rdata, e.rdata);
                end
                check_val("sel_cycles", sel_run, e.sel_cycles);
            end
            sel_run = 0;
        end else if (io_bus_sel) begin
            sel_run++;
        end else if (!cpu_busy) begin
            sel_run = 0;
        end
    end

    // One full transaction with the expected outcome derived from the request.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int delay, input logic [31:0] rd);
        exp_t e;
        logic inwin;
        logic acked;
        int   start;
        inwin        = ((addr & 32'hFFFF_0000) == 32'hFFFF_0000);
        acked        = inwin && (delay >= 0) && (delay < c_timeout);
        e.err        = !acked;
        e.chk_rdata  = inwin;
        e.rdata      = (acked && !we) ? rd : 32'h0;
        e.sel_cycles = !inwin ? 0 : (acked ? delay + 1 : c_timeout);
        exp_q.push_back(e);
        ack_delay   = delay;
        slave_rdata = rd;
        cpu_req     = 1'b1;
        cpu_we      = we;
        cpu_addr    = addr;
        cpu_wdata   = wdata;
        start       = done_cnt;
        step();
        cpu_req = 1'b0;
        check_val("t1_sel", {31'b0, io_bus_sel}, {31'b0, inwin});
        check_val("t1_done", {31'b0, cpu_done}, {31'b0, !inwin});
        check_val("t1_busy", {31'b0, cpu_busy}, 32'd1);
        if (inwin) begin
            check_val("t1_addr", io_bus_addr, addr);
            check_val("t1_dat2", io_bus_dat2, wdata);
            check_val("t1_we", {31'b0, io_bus_we}, {31'b0, we});
        end
        for (int i = 0; i < 20 && done_cnt == start; i++) begin
            step();
        end
        if (done_cnt == start) begin
            check_val("done_timeout", 32'd0, 32'd1);
        end
        step();
        check_val("idle_busy", {31'b0, cpu_busy}, 32'd0);
    endtask

    // Directed sequence.
    initial begin
        int start;
        reset = 1'b1;
        step();
        step();
        check_val("rst_rdata", cpu_rdata, 32'h0);
        check_val("rst_done", {31'b0, cpu_done}, 32'd0);
        check_val("rst_err", {31'b0, cpu_err}, 32'd0);
        check_val("rst_busy", {31'b0, cpu_busy}, 32'd0);
        check_val("rst_addr", io_bus_addr, 32'h0);
        check_val("rst_dat2", io_bus_dat2, 32'h0);
        check_val("rst_sel", {31'b0, io_bus_sel}, 32'd0);
        check_val("rst_we", {31'b0, io_bus_we}, 32'd0);
        reset = 1'b0;
        step();

        // Read with ack two cycles after sel.
        do_req(1'b0, 32'hFFFF_0010, 32'h0, 2, 32'hDEAD_BEEF);
        // Write with same-cycle ack; rdata must clear.
        do_req(1'b1, 32'hFFFF_0004, 32'h0000_00E3, 0, 32'h5555_AAAA);
        // Out-of-window request.
        do_req(1'b0, 32'h0000_1000, 32'h0, 0, 32'h1111_2222);
        // Slave never acks: abort after TIMEOUT cycles.
        do_req(1'b0, 32'hFFFF_0020, 32'h0, -1, 32'h3333_4444);
        // Ack on the final cycle wins over the abort.
        do_req(1'b0, 32'hFFFF_0024, 32'h0, 3, 32'hCAFE_F00D);
        do_req(1'b1, 32'hFFFF_0028, 32'h1234_0000, 3, 32'h7777_7777);

        // Reset in the middle of a bus cycle.
        ack_delay = -1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'hFFFF_0030;
        step();
        cpu_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_val("midrst_sel", {31'b0, io_bus_sel}, 32'd0);
        check_val("midrst_busy", {31'b0, cpu_busy}, 32'd0);
        check_val("midrst_done", {31'b0, cpu_done}, 32'd0);
        reset = 1'b0;
        step();
        do_req(1'b0, 32'hFFFF_0034, 32'h0, 1, 32'hA5A5_5A5A);

        // Request held high with same-cycle ack and stray ack while idle.
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.rdata      = 32'h1234_5678;
            e.err        = 1'b0;
            e.chk_rdata  = 1'b1;
            e.sel_cycles = 1;
            exp_q.push_back(e);
        end
        ack_delay   = 0;
        slave_rdata = 32'h1234_5678;
        stray_ack   = 1'b1;
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 32'hFFFF_0040;
        start       = done_cnt;
        for (int k = 1; k <= 9; k++) begin
            step();
            check_val("b2b_sel", {31'b0, io_bus_sel}, {31'b0, (k % 3) == 1});
        end
        cpu_req = 1'b0;
        step();
        check_val("b2b_count", done_cnt - start, 32'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("stray_busy", {31'b0, cpu_busy}, 32'd0);
            check_val("stray_done", {31'b0, cpu_done}, 32'd0);
            check_val("stray_rdata", cpu_rdata, 32'h1234_5678);
        end
        stray_ack = 1'b0;
        step();
        check_val("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
